pool_frame_ctrl: RTL and testbench
==================================

# pool_frame_ctrl

Frame sequencer for the 2x2 max-pooling layer. It takes pixel vectors from an upstream valid/ready buffer and drives the pooling datapath with a raster stream over the full W_WIDTH x W_HEIGHT frame: enable, pixels, and vcnt/hcnt coordinates, with blanking inserted. It then monitors the datapath's result pulses to decide when the frame is complete. It sits between the inter-layer line/FIFO buffer and the pooling instance, and hands a done/error status to the network-level scheduler.

## Interface
- WIDTH, -1, active image width; must be even.
- HEIGHT, -1, active image height; must be even.
- W_WIDTH, -1, frame width including horizontal blanking; must be greater than WIDTH.
- W_HEIGHT, -1, frame height including vertical blanking; must be at least HEIGHT.
- FIXED_BITW, -1, bits per pixel per unit.
- UNITS, -1, channels per pixel vector.
- FLUSH_MAX, 64, maximum flush cycles before timeout.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start request; ignored unless IDLE.
- s_valid  in  1  upstream pixel available.
- s_pixels  in  FIXED_BITW*UNITS  upstream pixel vector.
- s_ready  out  1  upstream pixel consumed this cycle.
- dp_enable  out  1  datapath input enable.
- dp_pixels  out  FIXED_BITW*UNITS  datapath pixel vector.
- dp_vcnt  out  log2(W_HEIGHT)  datapath vertical coordinate.
- dp_hcnt  out  log2(W_WIDTH)  datapath horizontal coordinate.
- dp_out_enable  in  1  pooled-result pulse from the datapath; one pulse per result.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle frame-complete pulse.
- err  out  1  sticky error flag (timeout or surplus result); cleared by an accepted start.

## Operation
- States: IDLE, ACTIVE, FLUSH, DONE.
- IDLE: the counters vcnt/hcnt and the result counter rcnt are held at 0. On start go to ACTIVE, clear err, clear rcnt.
- ACTIVE: the internal position (v,h) sweeps the raster, with h running fastest.
  - Active area is h<WIDTH and v<HEIGHT. Here s_ready = s_valid-independent 1, combinational from state and position. On the handshake (s_valid & s_ready) the position advances.
  - When s_valid is 0, the position stalls and dp_enable is 0 the next cycle.
  - Blanking area: s_ready=0. The position advances every cycle; dp_pixels is 0 and dp_enable is 1.
  - Advance rule: h=W_WIDTH-1 wraps h to 0 and increments v. Advancing from (W_HEIGHT-1, W_WIDTH-1) goes to FLUSH instead of wrapping.
- FLUSH: dp_enable=0. dp_vcnt/dp_hcnt hold their last values. A flush cycle counter runs.
  - Exit to DONE when rcnt = RESULTS = (HEIGHT/2)*(WIDTH/2).
  - Also exit to DONE when the flush counter reaches FLUSH_MAX; in that case set err.
- DONE: done=1 for exactly one cycle, then IDLE.
- rcnt increments on every dp_out_enable=1 cycle while the state is ACTIVE or FLUSH. It saturates at RESULTS. A pulse arriving when rcnt is already RESULTS sets err.
- dp_out_enable in IDLE or DONE is ignored.
- start while busy is ignored and has no effect on err.
- rst at any cycle gives state IDLE and all counters 0 on the next edge, with no done pulse.

## Timing
- Reset values: s_ready=0, dp_enable=0, dp_pixels=0, dp_vcnt=0, dp_hcnt=0, busy=0, done=0, err=0.
- start sampled at edge T gives busy=1 from T+1. s_ready may be 1 in cycle T+1.
- dp_* outputs are registered. A handshake or blanking step for position (v,h) in cycle t drives dp_enable=1, dp_vcnt=v, dp_hcnt=h, and the pixels in cycle t+1.
- With s_valid held at 1, one full frame takes exactly W_WIDTH*W_HEIGHT ACTIVE cycles.
- done is asserted in the cycle after the FLUSH exit condition is seen. busy falls together with done falling.
- A result pulse arriving in the same cycle as the FLUSH timeout counts first: if it completes RESULTS, there is no error.

## Test plan
- WIDTH=4, HEIGHT=4, W_WIDTH=6, W_HEIGHT=5, s_valid=1, and a datapath model giving 4 pulses → 30 dp_enable cycles with coordinates (0,0)..(4,5) in order, s_ready high for exactly 16 cycles, done pulses once, err=0.
- Same setup with s_valid toggling 1/0 → coordinate sequence identical to the first test with no duplicates, dp_enable=0 during stalls, upstream data order preserved.
- Only 3 result pulses, FLUSH_MAX=8 → done fires 8 cycles into FLUSH, err=1, err is cleared by the next accepted start.
- 5 result pulses → err=1 on the fifth, rcnt stays at 4, done still pulses.
- start asserted during ACTIVE → ignored, and the frame completes normally.
- rst asserted mid-ACTIVE at position (2,3) → next cycle all outputs are at reset values, state is IDLE, no done pulse; a fresh start restarts at (0,0).

Source files
------------

// File: rtl/pool_frame_ctrl.sv
// pool_frame_ctrl: raster frame sequencer for the 2x2 max-pooling datapath.
// Pulls pixel vectors from the upstream buffer over the active area, inserts
// blanking steps up to the full W_WIDTH x W_HEIGHT frame, then waits for the
// datapath's pooled-result pulses (bounded by FLUSH_MAX) before reporting done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; position and result count held at 0
// ST_ACTIVE | sweeping the raster; handshake in active area, free-run in blanking
// ST_FLUSH  | raster finished; waiting for remaining results or timeout
// ST_DONE   | one-cycle done pulse, then back to idle
module pool_frame_ctrl #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int W_WIDTH    = 6,
    parameter int W_HEIGHT   = 5,
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 2,
    parameter int FLUSH_MAX  = 64,
    localparam int PIX_W     = FIXED_BITW * UNITS,
    localparam int V_W       = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
    localparam int H_W       = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_pixels,
    output logic             s_ready,
    output logic             dp_enable,
    output logic [PIX_W-1:0] dp_pixels,
    output logic [V_W-1:0]   dp_vcnt,
    output logic [H_W-1:0]   dp_hcnt,
    input  logic             dp_out_enable,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RESULTS = (HEIGHT / 2) * (WIDTH / 2);
    localparam int R_W     = $clog2(RESULTS + 1);
    localparam int F_W     = (FLUSH_MAX > 1) ? $clog2(FLUSH_MAX) : 1;

    // Extra bit on the active-area bounds: HEIGHT may equal W_HEIGHT.
    localparam logic [V_W:0]   V_ACT  = (V_W + 1)'(HEIGHT);
    localparam logic [H_W:0]   H_ACT  = (H_W + 1)'(WIDTH);
    localparam logic [V_W-1:0] V_LAST = V_W'(W_HEIGHT - 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(W_WIDTH - 1);
    localparam logic [R_W-1:0] R_FULL = R_W'(RESULTS);
    localparam logic [F_W-1:0] F_LOAD = F_W'(FLUSH_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [V_W-1:0]     v_q, v_d;
    logic [H_W-1:0]     h_q, h_d;
    logic [R_W-1:0]     rcnt_q, rcnt_d;
    logic [F_W-1:0]     flush_q, flush_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               dp_enable_q, dp_enable_d;
    logic [PIX_W-1:0]   dp_pixels_q, dp_pixels_d;
    logic [V_W-1:0]     dp_vcnt_q, dp_vcnt_d;
    logic [H_W-1:0]     dp_hcnt_q, dp_hcnt_d;

    logic in_active;
    logic step;
    logic pulse_ok;
    logic surplus;

    // Position classification and result-pulse qualification.
    always_comb begin
        in_active = ({1'b0, v_q} < V_ACT) && ({1'b0, h_q} < H_ACT);
        step      = in_active ? s_valid : 1'b1;
        pulse_ok  = dp_out_enable && ((state_q == ST_ACTIVE) || (state_q == ST_FLUSH));
        surplus   = pulse_ok && (rcnt_q == R_FULL);
    end

    // s_ready is deliberately independent of s_valid.
    assign s_ready = (state_q == ST_ACTIVE) && in_active;

    // Next-state, raster advance, result counting and registered-output logic.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        h_d         = h_q;
        rcnt_d      = rcnt_q;
        flush_d     = flush_q;
        err_d       = err_q;
        done_d      = 1'b0;
        dp_enable_d = 1'b0;
        dp_pixels_d = dp_pixels_q;
        dp_vcnt_d   = dp_vcnt_q;
        dp_hcnt_d   = dp_hcnt_q;

        // Result pulses count first so a completing pulse beats a same-cycle timeout.
        if (pulse_ok) begin
            if (surplus) begin
                err_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                v_d         = '0;
                h_d         = '0;
                rcnt_d      = '0;
                flush_d     = '0;
                dp_pixels_d = '0;
                dp_vcnt_d   = '0;
                dp_hcnt_d   = '0;
                if (start) begin
                    state_d = ST_ACTIVE;
                    err_d   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (step) begin
                    dp_enable_d = 1'b1;
                    dp_vcnt_d   = v_q;
                    dp_hcnt_d   = h_q;
                    dp_pixels_d = in_active ? s_pixels : '0;
                    if (h_q == H_LAST) begin
                        h_d = '0;
                        if (v_q == V_LAST) begin
                            v_d     = '0;
                            flush_d = F_LOAD;
                            state_d = ST_FLUSH;
                        end else begin
                            v_d = v_q + 1'b1;
                        end
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (rcnt_d == R_FULL) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (flush_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                dp_pixels_d = '0;
                dp_vcnt_d   = '0;
                dp_hcnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            h_q         <= '0;
            rcnt_q      <= '0;
            flush_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dp_enable_q <= 1'b0;
            dp_pixels_q <= '0;
            dp_vcnt_q   <= '0;
            dp_hcnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            h_q         <= h_d;
            rcnt_q      <= rcnt_d;
            flush_q     <= flush_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dp_enable_q <= dp_enable_d;
            dp_pixels_q <= dp_pixels_d;
            dp_vcnt_q   <= dp_vcnt_d;
            dp_hcnt_q   <= dp_hcnt_d;
        end
    end

    assign dp_enable = dp_enable_q;
    assign dp_pixels = dp_pixels_q;
    assign dp_vcnt   = dp_vcnt_q;
    assign dp_hcnt   = dp_hcnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Bench for pool_frame_ctrl: 4x4 active area in a 6x5 frame, FLUSH_MAX=8.
// A reference model tracks the expected raster index and derives done/err
// timing from the recorded result pulses after each frame.
module tb_pool_frame_ctrl;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int WW  = 6;
    localparam int WH  = 5;
    localparam int BW  = 8;
    localparam int UN  = 2;
    localparam int FM  = 8;
    localparam int PW  = BW * UN;
    localparam int RES = (H / 2) * (W / 2);
    localparam int TOTAL = WW * WH;

    logic          clock;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [PW-1:0] s_pixels;
    logic          s_ready;
    logic          dp_enable;
    logic [PW-1:0] dp_pixels;
    logic [2:0]    dp_vcnt;
    logic [2:0]    dp_hcnt;
    logic          dp_out_enable;
    logic          busy;
    logic          done;
    logic          err;

    int n_chk = 0;
    int n_err = 0;

    pool_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .W_WIDTH(WW), .W_HEIGHT(WH),
        .FIXED_BITW(BW), .UNITS(UN), .FLUSH_MAX(FM)
    ) dut (
        .clock(clock),
        .rst(rst),
        .start(start),
        .s_valid(s_valid),
        .s_pixels(s_pixels),
        .s_ready(s_ready),
        .dp_enable(dp_enable),
        .dp_pixels(dp_pixels),
        .dp_vcnt(dp_vcnt),
        .dp_hcnt(dp_hcnt),
        .dp_out_enable(dp_out_enable),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit act(input int k);
        return ((k / WW) < H) && ((k % WW) < W);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_dp_enable"}, 32'(dp_enable), 32'd0);
        chk({tag, "_dp_pixels"}, 32'(dp_pixels), 32'd0);
        chk({tag, "_dp_vcnt"}, 32'(dp_vcnt), 32'd0);
        chk({tag, "_dp_hcnt"}, 32'(dp_hcnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // vmode: 0 s_valid=1, 1 toggling, 2 random. npulse: result pulses supplied
    // by the datapath model. rst_at: raster index at which rst is applied (-1 none).
    task automatic run_frame(input int vmode, input int npulse, input bit mid_start,
                             input bit start_on_done, input int rst_at);
        int k, cyc, f_cyc, done_cyc, n_done, en_cnt, rdy_cnt, hs_cnt;
        int exp_v, exp_h, b, c_res, exp_done, p5;
        bit exp_en, exp_to, exp_err, stp, finished;
        logic [PW-1:0] exp_pix;
        int due[$];
        int pcyc[$];
        int err_at[0:511];

        k = 0; f_cyc = -1; done_cyc = -1; n_done = 0; en_cnt = 0;
        rdy_cnt = 0; hs_cnt = 0; exp_v = 0; exp_h = 0; exp_en = 1'b0;
        exp_pix = '0; finished = 1'b0;
        for (int i = 0; i < 512; i++) err_at[i] = 0;

        start = 1'b1; s_valid = 1'b0; dp_out_enable = 1'b0; s_pixels = '0;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("err_cleared_by_start", 32'(err), 32'd0);

        while (!finished && cyc < 400) begin
            err_at[cyc] = 32'(err);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("done_single_cycle", 32'(done), 32'd0);
                finished = 1'b1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
                chk("dp_enable", 32'(dp_enable), 32'(exp_en));
                if (exp_en) begin
                    chk("dp_vcnt", 32'(dp_vcnt), 32'(exp_v));
                    chk("dp_hcnt", 32'(dp_hcnt), 32'(exp_h));
                    chk("dp_pixels", 32'(dp_pixels), 32'(exp_pix));
                    en_cnt++;
                    f_cyc = cyc;
                    // datapath model: a 2x2 block completes on its bottom-right pixel
                    if ((exp_v % 2 == 1) && (exp_h % 2 == 1) && exp_v < H && exp_h < W) begin
                        b = (exp_v / 2) * (W / 2) + exp_h / 2;
                        if (b < npulse && b < RES) due.push_back(cyc + 2);
                        if (npulse > RES && b == RES - 1) due.push_back(cyc + 3);
                    end
                end
                if (done) begin
                    n_done++;
                    if (done_cyc < 0) done_cyc = cyc;
                end

                case (vmode)
                    0:       s_valid = 1'b1;
                    1:       s_valid = (cyc % 2 == 1);
                    default: s_valid = 1'($urandom_range(0, 1));
                endcase
                s_pixels = PW'($urandom);
                dp_out_enable = 1'b0;
                if (due.size() > 0 && due[0] == cyc) begin
                    void'(due.pop_front());
                    dp_out_enable = 1'b1;
                    pcyc.push_back(cyc);
                end
                start = (mid_start && cyc == 5) || (start_on_done && done);
                rst = (rst_at >= 0 && k == rst_at && k < TOTAL);
                #1;
                chk("s_ready", 32'(s_ready), 32'((k < TOTAL) && act(k)));
                if (s_ready) rdy_cnt++;
                if (s_ready && s_valid) hs_cnt++;

                if (rst) begin
                    tick();
                    chk_reset_outputs("mid_rst");
                    rst = 1'b0; start = 1'b0; s_valid = 1'b0; dp_out_enable = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        tick();
                        chk("rst_no_done", 32'(done), 32'd0);
                        chk("rst_idle", 32'(busy), 32'd0);
                    end
                    return;
                end

                if (k < TOTAL) begin
                    stp = act(k) ? s_valid : 1'b1;
                    exp_en = stp;
                    if (stp) begin
                        exp_v = k / WW;
                        exp_h = k % WW;
                        exp_pix = act(k) ? s_pixels : '0;
                        k++;
                    end
                end else begin
                    exp_en = 1'b0;
                end
                tick();
                start = 1'b0;
                dp_out_enable = 1'b0;
                cyc++;
            end
        end

        if (!finished) begin
            chk("frame_cycle_budget", 32'd1, 32'd0);
        end else begin
            c_res = (pcyc.size() >= RES) ? pcyc[RES-1] : -1;
            if (c_res >= 0 && c_res <= f_cyc + FM - 1) begin
                exp_done = ((c_res > f_cyc) ? c_res : f_cyc) + 1;
                exp_to = 1'b0;
            end else begin
                exp_done = f_cyc + FM;
                exp_to = 1'b1;
            end
            exp_err = exp_to || (pcyc.size() > RES);
            chk("en_count", 32'(en_cnt), 32'(TOTAL));
            chk("handshake_count", 32'(hs_cnt), 32'(W * H));
            if (vmode == 0) chk("ready_count", 32'(rdy_cnt), 32'(W * H));
            chk("done_count", 32'(n_done), 32'd1);
            chk("done_cycle", 32'(done_cyc), 32'(exp_done));
            chk("err_final", 32'(err), 32'(exp_err));
            if (pcyc.size() > RES) begin
                p5 = pcyc[RES];
                chk("err_before_surplus", 32'(err_at[p5]), 32'd0);
                chk("err_after_surplus", 32'(err_at[p5 + 1]), 32'd1);
            end
        end
        start = 1'b0; s_valid = 1'b0; dp_out_enable = 1'b0;
        tick();
        chk("idle_between_frames", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_pixels = '0; dp_out_enable = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run_frame(0, 4, 1'b0, 1'b0, -1);
        run_frame(1, 4, 1'b0, 1'b0, -1);
        run_frame(0, 3, 1'b0, 1'b1, -1);
        run_frame(2, 4, 1'b1, 1'b0, -1);
        run_frame(0, 5, 1'b0, 1'b0, -1);
        run_frame(1, 4, 1'b0, 1'b0, 15);
        run_frame(2, 4, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
